// File: rtl/alu4.sv
`default_nettype none
// ============================================================================
// Module   : alu4
// Brief    : Registered WIDTH-bit ALU with eight operations selected by m.
//            Result and carry/borrow/overflow flag are registered, so every
//            operation has a latency of exactly one clock.
// Revision : 1.0 - initial release
// ============================================================================
module alu4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [2:0]       m,
    output logic [WIDTH-1:0] r,
    output logic             of
);

    // Operation codes
    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_CMP = 3'b010;
    localparam logic [2:0] c_OP_AND = 3'b011;
    localparam logic [2:0] c_OP_OR  = 3'b100;
    localparam logic [2:0] c_OP_NOT = 3'b101;
    localparam logic [2:0] c_OP_INC = 3'b110;
    localparam logic [2:0] c_OP_DEC = 3'b111;

    localparam logic [WIDTH:0] c_ONE = {{WIDTH{1'b0}}, 1'b1};

    // Operands extended by one bit so the top bit of each result is the
    // carry (for sums) or the borrow (for differences).
    logic [WIDTH:0]   w_a_ext;
    logic [WIDTH:0]   w_b_ext;
    logic [WIDTH:0]   w_cin_ext;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_inc;
    logic [WIDTH:0]   w_dec;
    logic [WIDTH-1:0] w_cmp;
    logic [WIDTH-1:0] w_res;
    logic             w_flag;
    logic [WIDTH-1:0] r_r;
    logic             r_of;

    assign w_a_ext   = {1'b0, a};
    assign w_b_ext   = {1'b0, b};
    assign w_cin_ext = {{WIDTH{1'b0}}, cin};

    // a - b - cin never goes below -2^WIDTH, so bit WIDTH of the wrapped
    // difference is set exactly when a < b + cin.
    assign w_sum  = w_a_ext + w_b_ext + w_cin_ext;
    assign w_diff = w_a_ext - w_b_ext - w_cin_ext;
    assign w_inc  = w_a_ext + c_ONE;
    assign w_dec  = w_a_ext - c_ONE;

    // Unsigned compare: one-hot {lt, eq, gt} in the low three bits
    always_comb begin
        w_cmp    = '0;
        w_cmp[0] = (a > b);
        w_cmp[1] = (a == b);
        w_cmp[2] = (a < b);
    end

    // Operation decode: select result and flag for the current mode
    always_comb begin
        w_res  = '0;
        w_flag = 1'b0;
        case (m)
            c_OP_ADD: begin
                w_res  = w_sum[WIDTH-1:0];
                w_flag = w_sum[WIDTH];
            end
            c_OP_SUB: begin
                w_res  = w_diff[WIDTH-1:0];
                w_flag = w_diff[WIDTH];
            end
            c_OP_CMP: w_res = w_cmp;
            c_OP_AND: w_res = a & b;
            c_OP_OR:  w_res = a | b;
            c_OP_NOT: w_res = ~a;
            c_OP_INC: begin
                w_res  = w_inc[WIDTH-1:0];
                w_flag = w_inc[WIDTH];
            end
            c_OP_DEC: begin
                w_res  = w_dec[WIDTH-1:0];
                w_flag = w_dec[WIDTH];
            end
            default: begin
                w_res  = '0;
                w_flag = 1'b0;
            end
        endcase
    end

    // Output register: reset wins, otherwise load a new result every edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_r  <= '0;
            r_of <= 1'b0;
        end else begin
            r_r  <= w_res;
            r_of <= w_flag;
        end
    end

    assign r  = r_r;
    assign of = r_of;

endmodule
`default_nettype wire

// File: tb/tb_alu4.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu4
// Brief    : Self-checking bench for alu4 using a table of directed vectors
//            with hand-computed results, plus short reset/hold sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu4;

    localparam int WIDTH = 4;
    localparam int NVEC  = 43;

    typedef struct {
        logic             rst;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [2:0]       m;
        logic [WIDTH-1:0] exp_r;
        logic             exp_of;
    } vec_t;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [2:0]       m;
    logic [WIDTH-1:0] r;
    logic             of;

    int   checks;
    int   errors;
    vec_t vecs [NVEC];

    alu4 #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .cin (cin),
        .m   (m),
        .r   (r),
        .of  (of)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] exp_r,
                         input logic exp_of);
        checks++;
        if (r !== exp_r || of !== exp_of) begin
            errors++;
            $display("FAIL %s: got r=%b of=%b, expected r=%b of=%b",
                     name, r, of, exp_r, exp_of);
        end
    endtask

    // Drive inputs on the falling edge, let one rising edge load them.
    task automatic apply(input logic v_rst, input logic [WIDTH-1:0] v_a,
                         input logic [WIDTH-1:0] v_b, input logic v_cin,
                         input logic [2:0] v_m);
        @(negedge clk);
        rst = v_rst;
        a   = v_a;
        b   = v_b;
        cin = v_cin;
        m   = v_m;
        @(posedge clk);
        #1;
    endtask

    task automatic setv(input int i, input logic v_rst, input logic [3:0] v_a,
                        input logic [3:0] v_b, input logic v_cin,
                        input logic [2:0] v_m, input logic [3:0] e_r,
                        input logic e_of);
        vecs[i].rst    = v_rst;
        vecs[i].a      = v_a;
        vecs[i].b      = v_b;
        vecs[i].cin    = v_cin;
        vecs[i].m      = v_m;
        vecs[i].exp_r  = e_r;
        vecs[i].exp_of = e_of;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; a = '0; b = '0; cin = 1'b0; m = 3'b000;

        //   idx rst a        b        cin   m       exp_r    exp_of
        // add
        setv( 0, 0, 4'b1111, 4'b0001, 1'b0, 3'b000, 4'b0000, 1'b1);
        setv( 1, 0, 4'b1010, 4'b0101, 1'b0, 3'b000, 4'b1111, 1'b0);
        setv( 2, 0, 4'b0111, 4'b1100, 1'b0, 3'b000, 4'b0011, 1'b1);
        setv( 3, 0, 4'b0001, 4'b0001, 1'b1, 3'b000, 4'b0011, 1'b0);
        setv( 4, 0, 4'b1111, 4'b1111, 1'b1, 3'b000, 4'b1111, 1'b1);
        setv( 5, 0, 4'b1110, 4'b0001, 1'b1, 3'b000, 4'b0000, 1'b1);
        // subtract
        setv( 6, 0, 4'b1111, 4'b1001, 1'b0, 3'b001, 4'b0110, 1'b0);
        setv( 7, 0, 4'b1010, 4'b0101, 1'b0, 3'b001, 4'b0101, 1'b0);
        setv( 8, 0, 4'b0111, 4'b1100, 1'b0, 3'b001, 4'b1011, 1'b1);
        setv( 9, 0, 4'b0000, 4'b0000, 1'b1, 3'b001, 4'b1111, 1'b1);
        setv(10, 0, 4'b0101, 4'b0011, 1'b1, 3'b001, 4'b0001, 1'b0);
        setv(11, 0, 4'b0011, 4'b0010, 1'b1, 3'b001, 4'b0000, 1'b0);
        setv(12, 0, 4'b0000, 4'b1111, 1'b1, 3'b001, 4'b0000, 1'b1);
        // compare
        setv(13, 0, 4'b1001, 4'b0001, 1'b0, 3'b010, 4'b0001, 1'b0);
        setv(14, 0, 4'b1010, 4'b0101, 1'b0, 3'b010, 4'b0001, 1'b0);
        setv(15, 0, 4'b0111, 4'b1100, 1'b0, 3'b010, 4'b0100, 1'b0);
        setv(16, 0, 4'b0110, 4'b0110, 1'b0, 3'b010, 4'b0010, 1'b0);
        setv(17, 0, 4'b0110, 4'b0110, 1'b1, 3'b010, 4'b0010, 1'b0);
        // and
        setv(18, 0, 4'b1001, 4'b0001, 1'b0, 3'b011, 4'b0001, 1'b0);
        setv(19, 0, 4'b1010, 4'b0101, 1'b0, 3'b011, 4'b0000, 1'b0);
        setv(20, 0, 4'b0111, 4'b1100, 1'b0, 3'b011, 4'b0100, 1'b0);
        setv(21, 0, 4'b1111, 4'b1010, 1'b1, 3'b011, 4'b1010, 1'b0);
        // or
        setv(22, 0, 4'b1001, 4'b0001, 1'b0, 3'b100, 4'b1001, 1'b0);
        setv(23, 0, 4'b1010, 4'b0101, 1'b0, 3'b100, 4'b1111, 1'b0);
        setv(24, 0, 4'b0111, 4'b1100, 1'b0, 3'b100, 4'b1111, 1'b0);
        setv(25, 0, 4'b0000, 4'b0000, 1'b1, 3'b100, 4'b0000, 1'b0);
        // complement (b and cin must not matter)
        setv(26, 0, 4'b1001, 4'b1111, 1'b0, 3'b101, 4'b0110, 1'b0);
        setv(27, 0, 4'b1010, 4'b0000, 1'b0, 3'b101, 4'b0101, 1'b0);
        setv(28, 0, 4'b0111, 4'b0011, 1'b1, 3'b101, 4'b1000, 1'b0);
        // increment
        setv(29, 0, 4'b1001, 4'b0000, 1'b0, 3'b110, 4'b1010, 1'b0);
        setv(30, 0, 4'b1010, 4'b0000, 1'b0, 3'b110, 4'b1011, 1'b0);
        setv(31, 0, 4'b0111, 4'b1111, 1'b1, 3'b110, 4'b1000, 1'b0);
        setv(32, 0, 4'b1111, 4'b0000, 1'b0, 3'b110, 4'b0000, 1'b1);
        setv(33, 0, 4'b1111, 4'b1111, 1'b1, 3'b110, 4'b0000, 1'b1);
        // decrement
        setv(34, 0, 4'b1001, 4'b0000, 1'b0, 3'b111, 4'b1000, 1'b0);
        setv(35, 0, 4'b1010, 4'b0000, 1'b0, 3'b111, 4'b1001, 1'b0);
        setv(36, 0, 4'b0111, 4'b0000, 1'b0, 3'b111, 4'b0110, 1'b0);
        setv(37, 0, 4'b0000, 4'b0101, 1'b1, 3'b111, 4'b1111, 1'b1);
        setv(38, 0, 4'b0001, 4'b1111, 1'b1, 3'b111, 4'b0000, 1'b0);
        // reset in the same cycle as an operation
        setv(39, 1, 4'b1111, 4'b0000, 1'b0, 3'b110, 4'b0000, 1'b0);
        setv(40, 0, 4'b0110, 4'b0011, 1'b0, 3'b000, 4'b1001, 1'b0);
        setv(41, 1, 4'b0111, 4'b1100, 1'b0, 3'b001, 4'b0000, 1'b0);
        setv(42, 1, 4'b0000, 4'b0000, 1'b0, 3'b111, 4'b0000, 1'b0);

        // Reset held for two cycles with arbitrary inputs
        apply(1'b1, 4'b1011, 4'b0110, 1'b1, 3'b000);
        check("reset_cycle1", 4'b0000, 1'b0);
        apply(1'b1, 4'b1111, 4'b1111, 1'b1, 3'b111);
        check("reset_cycle2", 4'b0000, 1'b0);

        // First operation after release appears after one edge
        apply(1'b0, 4'b0001, 4'b0001, 1'b0, 3'b000);
        check("first_add", 4'b0010, 1'b0);

        // Stable inputs: output holds its value
        @(posedge clk);
        #1;
        check("hold_stable", 4'b0010, 1'b0);

        // Table of vectors
        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].m);
            check($sformatf("vec%0d_m%b", i, vecs[i].m),
                  vecs[i].exp_r, vecs[i].exp_of);
        end

        // Load a flagged result, then reset mid-stream discards it
        apply(1'b0, 4'b0000, 4'b0000, 1'b0, 3'b111);
        check("pre_reset_dec", 4'b1111, 1'b1);
        apply(1'b1, 4'b1111, 4'b0001, 1'b0, 3'b000);
        check("midstream_reset", 4'b0000, 1'b0);
        apply(1'b0, 4'b1111, 4'b0001, 1'b0, 3'b000);
        check("post_reset_add", 4'b0000, 1'b1);

        // Back-to-back operations: each edge loads a fresh result
        apply(1'b0, 4'b0011, 4'b0101, 1'b0, 3'b010);
        check("b2b_cmp", 4'b0100, 1'b0);
        apply(1'b0, 4'b0011, 4'b0101, 1'b0, 3'b100);
        check("b2b_or", 4'b0111, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
